bus_responder: RTL and testbench
================================

// Module: bus_responder
// PURPOSE
//  Responder end of the SDSU bus. A bus master writes two operands with valid/address/data,
//  then pulses start. This block computes the result and returns it on result_data with a
//  one-cycle ready pulse. It sits between the master and the datapath, and supersedes the
//  direct master-to-register-file hookup.
// PARAMETERS
//  DATA_W       32  width of data and result_data
//  ADDR_W       32  width of address
//  COMPUTE_LAT   2  cycles spent in BUSY before DONE (>=1)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  valid        in   1       write strobe for address/data
//  start        in   1       compute request (single-cycle pulse expected)
//  address      in   ADDR_W  1 = operand A, 2 = operand B; any other value is illegal
//  data         in   DATA_W  write data
//  ready        out  1       one-cycle pulse: result_data is valid
//  result_data  out  DATA_W  A+B mod 2^DATA_W; held until the next DONE
//  overflow     out  1       carry out of A+B; updated with result_data
//  busy         out  1       high in BUSY and DONE
//  err          out  1       sticky: illegal address, write while busy, or start while busy
//  err_clr      in   1       clears err (lower priority than a same-cycle new error)
// BEHAVIOUR
//  - Reset (async assert, sync release): ready=0, result_data=0, overflow=0, busy=0, err=0,
//    op A=0, op B=0, state=IDLE, latency counter=0.
//  - FSM IDLE -> BUSY on start; BUSY -> DONE when counter reaches COMPUTE_LAT-1;
//    DONE -> IDLE unconditionally after 1 cycle.
//  - Writes: with valid=1 in IDLE and address in {1,2}, the operand is written at that edge.
//    address 0 or >2: write dropped, err set.
//  - valid=1 in BUSY or DONE: write dropped, err set; operands stay frozen during compute.
//  - start in IDLE: operands are snapshotted at that edge; the counter is cleared.
//    start in BUSY or DONE: ignored, err set. No queueing.
//  - valid and start in the same IDLE cycle: the write commits to the register file. The
//    snapshot takes the pre-write value, so that write affects only the next computation.
//  - In DONE: ready=1 for exactly that cycle. result_data and overflow are registered at the
//    BUSY->DONE edge.
//  - Latency: start sampled at edge N -> ready high in cycle N+COMPUTE_LAT+1, i.e. ready is
//    high after edge N+COMPUTE_LAT.
//  - Arithmetic: the sum is (DATA_W+1) bits wide. The low DATA_W bits go to result_data and
//    the MSB goes to overflow (wrap-around, no saturation).
//  - Reset mid-operation: any state returns to IDLE immediately and all outputs clear. A
//    pending result is lost and no ready pulse is produced.
//  - err_clr and a new error in the same cycle: err stays 1.
// STRUCTURE
//  - Package sdsu_bus_pkg:
//      typedef enum logic[1:0] {IDLE, BUSY, DONE} resp_state_t;
//      localparam ADDR_OP_A = 1, ADDR_OP_B = 2.
//  - Sub-module operand_regfile holds the two DATA_W registers. Its ports are
//    clk, rst_n, we, waddr, wdata, op_a, op_b.
//  - The FSM, counter, snapshot and adder live in bus_responder.
// TESTING
//  1 Reset: drive rst_n=0 mid-BUSY -> all outputs 0 at once, state IDLE, no ready after release.
//  2 Basic: write A=0x0000_0005 @1, B=0x0000_0007 @2, pulse start -> ready exactly one cycle,
//    COMPUTE_LAT+1 cycles later; result_data=0x0000_000C, overflow=0.
//  3 Wrap: A=0xFFFF_FFFF, B=0x0000_0002, start -> result_data=0x0000_0001, overflow=1.
//  4 Illegal: valid with address=0 then address=3 -> err=1, operands unchanged.
//    Then err_clr -> err=0.
//  5 Busy collisions: start, then during BUSY valid @1 data=0x99 and a second start -> err=1,
//    exactly one ready, result from the original operands.
//  6 Same-cycle: A=3, B=4; valid @1 data=10 together with start -> result=7;
//    next start -> result=14.

Source files
------------

// File: rtl/sdsu_bus_pkg.sv
// Shared types and address map for the SDSU bus responder.
package sdsu_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } resp_state_t;

   localparam int ADDR_OP_A = 1;
   localparam int ADDR_OP_B = 2;

endpackage

// File: rtl/operand_regfile.sv
// Two-entry operand register file written by the bus master.
// Only addresses ADDR_OP_A and ADDR_OP_B are decoded here.
// The caller gates 'we' so that only legal, idle-time writes arrive.
module operand_regfile
   import sdsu_bus_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b
);

   logic [DATA_W-1:0] r_opA;
   logic [DATA_W-1:0] r_opB;

   // Operand storage: write the addressed register, clear both on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opA <= '0;
         r_opB <= '0;
      end else if (we) begin
         if (waddr == ADDR_W'(ADDR_OP_A)) begin
            r_opA <= wdata;
         end else if (waddr == ADDR_W'(ADDR_OP_B)) begin
            r_opB <= wdata;
         end
      end
   end

   assign op_a = r_opA;
   assign op_b = r_opB;

endmodule

// File: rtl/bus_responder.sv
// Responder end of the SDSU bus.
// It accepts operand writes while idle and adds the operands on a start pulse.
// The sum is returned together with a one-cycle ready pulse.
module bus_responder
   import sdsu_bus_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int COMPUTE_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid,
   input  logic              start,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   input  logic              err_clr,
   output logic              ready,
   output logic [DATA_W-1:0] result_data,
   output logic              overflow,
   output logic              busy,
   output logic              err
);

   localparam int CNT_W = (COMPUTE_LAT > 1) ? $clog2(COMPUTE_LAT) : 1;

   resp_state_t       r_state;
   resp_state_t       w_nextState;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_snapA;
   logic [DATA_W-1:0] r_snapB;
   logic [DATA_W-1:0] r_result;
   logic              r_overflow;
   logic              r_err;

   logic [DATA_W-1:0] w_opA;
   logic [DATA_W-1:0] w_opB;
   logic [DATA_W:0]   w_sum;
   logic              w_idle;
   logic              w_addrLegal;
   logic              w_we;
   logic              w_cntDone;
   logic              w_errEvent;

   assign w_idle      = (r_state == IDLE);
   assign w_addrLegal = (address == ADDR_W'(ADDR_OP_A)) || (address == ADDR_W'(ADDR_OP_B));
   assign w_we        = valid && w_idle && w_addrLegal;
   assign w_cntDone   = (r_cnt == CNT_W'(COMPUTE_LAT - 1));
   assign w_errEvent  = (valid && (!w_idle || !w_addrLegal)) || (start && !w_idle);
   assign w_sum       = {1'b0, r_snapA} + {1'b0, r_snapB};

   operand_regfile #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_regfile (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (w_we),
      .waddr(address),
      .wdata(data),
      .op_a (w_opA),
      .op_b (w_opB)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: one pass through BUSY and DONE per accepted start
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (start) w_nextState = BUSY;
         BUSY:    if (w_cntDone) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Latency counter: cleared by an accepted start, advances while BUSY
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_idle && start) begin
         r_cnt <= '0;
      end else if (r_state == BUSY && !w_cntDone) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Snapshot the pre-write operands when a start is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snapA <= '0;
         r_snapB <= '0;
      end else if (w_idle && start) begin
         r_snapA <= w_opA;
         r_snapB <= w_opB;
      end
   end

   // Register the sum on the BUSY to DONE edge and hold it until the next DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result   <= '0;
         r_overflow <= 1'b0;
      end else if (r_state == BUSY && w_cntDone) begin
         r_result   <= w_sum[DATA_W-1:0];
         r_overflow <= w_sum[DATA_W];
      end
   end

   // Sticky error flag: a new error wins over a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_errEvent) begin
         r_err <= 1'b1;
      end else if (err_clr) begin
         r_err <= 1'b0;
      end
   end

   assign ready       = (r_state == DONE);
   assign busy        = !w_idle;
   assign result_data = r_result;
   assign overflow    = r_overflow;
   assign err         = r_err;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder.
// Expected values come from an operand/error model and from plain wide addition.
module tb_bus_responder;

   localparam int DATA_W      = 32;
   localparam int ADDR_W      = 32;
   localparam int COMPUTE_LAT = 2;

   logic              clk;
   logic              rst_n;
   logic              valid;
   logic              start;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data;
   logic              err_clr;
   logic              ready;
   logic [DATA_W-1:0] result_data;
   logic              overflow;
   logic              busy;
   logic              err;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: operand contents and sticky error as seen by the master
   logic [DATA_W-1:0] mA;
   logic [DATA_W-1:0] mB;
   logic              mErr;

   bus_responder #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .COMPUTE_LAT(COMPUTE_LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid      (valid),
      .start      (start),
      .address    (address),
      .data       (data),
      .err_clr    (err_clr),
      .ready      (ready),
      .result_data(result_data),
      .overflow   (overflow),
      .busy       (busy),
      .err        (err)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of bus inputs across a rising edge, then return to idle levels
   task automatic applyStimulus(input logic v, input logic s, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input logic clr);
      valid   = v;
      start   = s;
      address = a;
      data    = d;
      err_clr = clr;
      tick();
      valid   = 1'b0;
      start   = 1'b0;
      err_clr = 1'b0;
   endtask

   function automatic bit legalAddr(input logic [ADDR_W-1:0] a);
      return (a == 1) || (a == 2);
   endfunction

   task automatic modelWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (!legalAddr(a)) mErr = 1'b1;
      else if (a == 1) mA = d;
      else mB = d;
   endtask

   task automatic writeOp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      applyStimulus(1'b1, 1'b0, a, d, 1'b0);
      modelWrite(a, d);
   endtask

   // Start a computation (optionally with a same-cycle write) and check the response
   task automatic runCompute(input string tag, input logic withWrite,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      logic [DATA_W:0] expSum;
      int k;
      expSum = {1'b0, mA} + {1'b0, mB};
      applyStimulus(withWrite, 1'b1, a, d, 1'b0);
      if (withWrite) modelWrite(a, d);
      checkOutput({tag, "_busy"}, 64'(busy), 64'(1));
      k = 0;
      while (ready !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      checkOutput({tag, "_latency"}, 64'(k), 64'(COMPUTE_LAT));
      checkOutput({tag, "_result"}, 64'(result_data), 64'(expSum[DATA_W-1:0]));
      checkOutput({tag, "_overflow"}, 64'(overflow), 64'(expSum[DATA_W]));
      tick();
      checkOutput({tag, "_readyPulse"}, 64'(ready), 64'(0));
      checkOutput({tag, "_idle"}, 64'(busy), 64'(0));
   endtask

   // Directed scenarios followed by randomized write/compute rounds
   initial begin
      logic [DATA_W:0] expSum;
      int readyCount;

      rst_n   = 1'b0;
      valid   = 1'b0;
      start   = 1'b0;
      address = '0;
      data    = '0;
      err_clr = 1'b0;
      mA      = '0;
      mB      = '0;
      mErr    = 1'b0;

      #12;
      checkOutput("reset_ready", 64'(ready), 64'(0));
      checkOutput("reset_result", 64'(result_data), 64'(0));
      checkOutput("reset_overflow", 64'(overflow), 64'(0));
      checkOutput("reset_busy", 64'(busy), 64'(0));
      checkOutput("reset_err", 64'(err), 64'(0));
      rst_n = 1'b1;
      tick();

      $display("[TB] basic add");
      writeOp(1, 32'h0000_0005);
      writeOp(2, 32'h0000_0007);
      runCompute("basic", 1'b0, '0, '0);
      checkOutput("basic_value", 64'(result_data), 64'h0000_000C);

      $display("[TB] wrap-around");
      writeOp(1, 32'hFFFF_FFFF);
      writeOp(2, 32'h0000_0002);
      runCompute("wrap", 1'b0, '0, '0);
      checkOutput("wrap_value", 64'(result_data), 64'h0000_0001);
      checkOutput("wrap_carry", 64'(overflow), 64'(1));

      $display("[TB] reset mid-operation");
      writeOp(1, 32'h0000_0011);
      writeOp(2, 32'h0000_0022);
      applyStimulus(1'b0, 1'b1, '0, '0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1, 32'h55, 1'b0);
      checkOutput("midrst_errBefore", 64'(err), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", 64'(busy), 64'(0));
      checkOutput("midrst_ready", 64'(ready), 64'(0));
      checkOutput("midrst_result", 64'(result_data), 64'(0));
      checkOutput("midrst_overflow", 64'(overflow), 64'(0));
      checkOutput("midrst_err", 64'(err), 64'(0));
      mA   = '0;
      mB   = '0;
      mErr = 1'b0;
      tick();
      rst_n = 1'b1;
      readyCount = 0;
      for (int i = 0; i < COMPUTE_LAT + 3; i++) begin
         tick();
         if (ready === 1'b1) readyCount++;
      end
      checkOutput("midrst_noReady", 64'(readyCount), 64'(0));
      runCompute("postrst", 1'b0, '0, '0);

      $display("[TB] illegal addresses");
      writeOp(1, 32'h0000_1000);
      writeOp(2, 32'h0000_0234);
      writeOp(0, 32'hDEAD_BEEF);
      checkOutput("illegal0_err", 64'(err), 64'(mErr));
      writeOp(3, 32'hCAFE_F00D);
      checkOutput("illegal3_err", 64'(err), 64'(1));
      runCompute("illegal", 1'b0, '0, '0);
      checkOutput("illegal_value", 64'(result_data), 64'h0000_1234);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      mErr = 1'b0;
      checkOutput("errclr", 64'(err), 64'(0));
      applyStimulus(1'b1, 1'b0, 0, 32'h1, 1'b1);
      mErr = 1'b1;
      checkOutput("errclr_vs_new", 64'(err), 64'(1));
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      mErr = 1'b0;
      checkOutput("errclr2", 64'(err), 64'(0));

      $display("[TB] busy collisions");
      writeOp(1, 32'h0000_0100);
      writeOp(2, 32'h0000_0023);
      expSum = {1'b0, mA} + {1'b0, mB};
      readyCount = 0;
      applyStimulus(1'b0, 1'b1, '0, '0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1, 32'h99, 1'b0);
      if (ready === 1'b1) readyCount++;
      applyStimulus(1'b0, 1'b1, '0, '0, 1'b0);
      if (ready === 1'b1) readyCount++;
      mErr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ready === 1'b1) readyCount++;
      end
      checkOutput("collide_err", 64'(err), 64'(1));
      checkOutput("collide_readyCount", 64'(readyCount), 64'(1));
      checkOutput("collide_result", 64'(result_data), 64'(expSum[DATA_W-1:0]));
      runCompute("collide_frozen", 1'b0, '0, '0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      mErr = 1'b0;

      $display("[TB] same-cycle write and start");
      writeOp(1, 32'd3);
      writeOp(2, 32'd4);
      runCompute("same1", 1'b1, 1, 32'd10);
      checkOutput("same1_value", 64'(result_data), 64'd7);
      runCompute("same2", 1'b0, '0, '0);
      checkOutput("same2_value", 64'(result_data), 64'd14);
      checkOutput("same_err", 64'(err), 64'(0));

      $display("[TB] randomized rounds");
      for (int r = 0; r < 16; r++) begin
         int nWrites;
         nWrites = int'($urandom_range(1, 3));
         for (int w = 0; w < nWrites; w++) begin
            writeOp(ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom));
         end
         runCompute("rand", $urandom_range(0, 1) == 1, ADDR_W'($urandom_range(1, 2)),
                    DATA_W'($urandom));
         checkOutput("rand_err", 64'(err), 64'(mErr));
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
         mErr = 1'b0;
         checkOutput("rand_errclr", 64'(err), 64'(0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
